// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receive path: default word width, synchroniser
// depth, bit-counter width and the channel encoding carried on word select.
`timescale 1ns/1ps
package i2s_pkg;

  localparam int I2S_WORD_WIDTH  = 16;
  localparam int I2S_SYNC_STAGES = 2;
  localparam int I2S_CNT_WIDTH   = 8;

  localparam logic I2S_CHNL_LEFT  = 1'b0;
  localparam logic I2S_CHNL_RIGHT = 1'b1;

  // Bit counter increment that sticks at all-ones on very long frames.
  function automatic logic [I2S_CNT_WIDTH-1:0] i2s_cnt_inc(input logic [I2S_CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + I2S_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for one asynchronous I2S line, with an optional
// rising-edge detector behind it (used for the bit clock only).
`timescale 1ns/1ps
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter int STAGES  = I2S_SYNC_STAGES,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous line through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value.
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic r_last;

      // One extra flop behind the chain; a 0->1 step across it marks a rise.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_last <= 1'b0;
        end else begin
          r_last <= o_sync;
        end
      end

      assign o_rise = o_sync & ~r_last;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver. Oversamples sclk/wsel/sdat in the clk_i domain,
// deserialises MSB-first words and presents each one with its channel on a
// single-entry valid/ready port. A word select change marks the LSB of the
// word for the previous channel. Optional macro I2S_RX_FRAME_ERR_EN adds a
// sticky frame_err_o flag for frames whose length differs from WORD_WIDTH.
`timescale 1ns/1ps
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int WORD_WIDTH = I2S_WORD_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sclk_i,
  input  logic                  wsel_i,
  input  logic                  sdat_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  lr_chnl_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o
`ifdef I2S_RX_FRAME_ERR_EN
  ,
  output logic                  frame_err_o
`endif
);

  logic w_sclk_s_unused, w_sclk_rise;
  logic w_wsel_s, w_wsel_rise_unused;
  logic w_sdat_s, w_sdat_rise_unused;

  i2s_sync_edge #(.EDGE_EN(1'b1)) u_sync_sclk (
    .clk_i (clk_i), .rst_ni(rst_ni), .i_async(sclk_i),
    .o_sync(w_sclk_s_unused), .o_rise(w_sclk_rise)
  );
  i2s_sync_edge #(.EDGE_EN(1'b0)) u_sync_wsel (
    .clk_i (clk_i), .rst_ni(rst_ni), .i_async(wsel_i),
    .o_sync(w_wsel_s), .o_rise(w_wsel_rise_unused)
  );
  i2s_sync_edge #(.EDGE_EN(1'b0)) u_sync_sdat (
    .clk_i (clk_i), .rst_ni(rst_ni), .i_async(sdat_i),
    .o_sync(w_sdat_s), .o_rise(w_sdat_rise_unused)
  );

  logic [I2S_CNT_WIDTH-1:0] r_cnt;
  logic [WORD_WIDTH-1:0]    r_shift;
  logic [WORD_WIDTH-1:0]    w_word;
  logic                     r_wprev;
  logic                     r_synced;
  logic                     w_chg;
  logic                     w_word_done;

  logic [WORD_WIDTH-1:0]    r_data;
  logic                     r_lr;
  logic                     r_valid;
  logic                     r_overrun;

  assign w_chg       = w_sclk_rise & (w_wsel_s ^ r_wprev);
  assign w_word_done = w_chg & r_synced;

  // Shift register with the current bit dropped into slot WORD_WIDTH-1-cnt;
  // bits beyond the word width leave it untouched (truncation).
  always_comb begin
    // NOTE: default assignment first so this block can never infer a latch.
    w_word = r_shift;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (int'(r_cnt) == WORD_WIDTH - 1 - i) w_word[i] = w_sdat_s;
    end
  end

  // Deserialiser: collect bits per sclk rise, restart on a word select change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_wprev  <= I2S_CHNL_LEFT;
      r_synced <= 1'b0;
    end else if (w_sclk_rise) begin
      if (w_chg) begin
        r_cnt    <= '0;
        r_shift  <= '0;
        r_synced <= 1'b1;
      end else begin
        r_shift <= w_word;
        r_cnt   <= i2s_cnt_inc(r_cnt);
      end
      r_wprev <= w_wsel_s;
    end
  end

  // Single-entry output stage: load when free or emptying, else drop and flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data    <= '0;
      r_lr      <= I2S_CHNL_LEFT;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_word_done) begin
      if (!r_valid || ready_i) begin
        r_data  <= w_word;
        r_lr    <= r_wprev;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o    = r_data;
  assign lr_chnl_o = r_lr;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;

`ifdef I2S_RX_FRAME_ERR_EN
  logic r_frame_err;

  // Sticky flag: a synced word ended after a bit count other than WORD_WIDTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_err <= 1'b0;
    end else if (w_word_done && (int'(r_cnt) != WORD_WIDTH - 1)) begin
      r_frame_err <= 1'b1;
    end
  end

  assign frame_err_o = r_frame_err;
`endif

endmodule
